// File: rtl/game_pkg.sv
// Shared definitions for the HUD numeric pipeline.
//   bcd_state_t : sequencing states of the serial binary-to-BCD converter
//   DIGIT_W     : bits per BCD digit
//   pow10(n)    : 10**n as a 64-bit constant, used at elaboration time
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    localparam int DIGIT_W = 4;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/dabble_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added,
// so the following left shift carries correctly into the next decade.
//   digit_in  : scratch digit before correction
//   digit_out : corrected digit
module dabble_digit
    import game_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/score_bcd_serial.sv
// Multi-cycle binary-to-BCD converter for score and HUD fields.
// A conversion takes BIN_W+1 cycles from the accepting edge to the done pulse.
// Values above 10**DIGITS-1 saturate to all nines and raise overflow.
// Results are held between conversions so the renderer can sample any time.
//   CLK, RESET  : clock, synchronous active-high reset
//   start/value : conversion request; sampled only while idle
//   busy        : conversion in progress
//   done        : one-cycle pulse when bcd/digit_valid/overflow update
//   bcd         : packed BCD result, ones digit in [3:0]
//   digit_valid : per-digit display enable (leading zeros masked if BLANK_LZ)
//   overflow    : last value was out of range and the result is saturated
// Handshake: start is honoured only in IDLE (including the done cycle);
// a start while busy is dropped, never queued.
module score_bcd_serial
    import game_pkg::*;
#(
    parameter int BIN_W    = 18,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      start,
    input  logic [BIN_W-1:0]          value,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]         digit_valid,
    output logic                      overflow
);

    localparam int          BCD_W   = DIGIT_W * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam bit          SAT_POSSIBLE =
        (BIN_W >= 64) || (((64'd1 << BIN_W) - 64'd1) > MAX_VAL);
    localparam logic [BCD_W-1:0]  NINES  = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] DV_RST = (BLANK_LZ != 0) ? DIGITS'(1) : {DIGITS{1'b1}};

    bcd_state_t        state_q, state_n;
    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  scratch_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sat_q;
    logic              sat_in;
    logic              do_load, do_shift, do_finish;
    logic [BCD_W-1:0]  corrected;
    logic [BCD_W-1:0]  shifted;
    logic [BCD_W-1:0]  result_n;
    logic [DIGITS-1:0] dv_n;
    logic              seen;

    // Range check only exists when the input can actually exceed MAX_VAL.
    if (SAT_POSSIBLE) begin : g_sat
        localparam int CMP_W = (BIN_W > 64) ? BIN_W : 64;
        assign sat_in = CMP_W'(value) > CMP_W'(MAX_VAL);
    end else begin : g_nosat
        assign sat_in = 1'b0;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        dabble_digit u_dabble (
            .digit_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (corrected[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected scratch shifts left, taking the binary MSB; the scratch MSB
    // falls off (only reachable when saturation overrides the result).
    assign shifted  = {corrected[BCD_W-2:0], bin_q[BIN_W-1]};
    assign result_n = sat_q ? NINES : scratch_q;

    // Digit i is shown if it or any more significant digit is nonzero;
    // the ones digit is always shown so zero reads as "0".
    always_comb begin
        dv_n = {DIGITS{1'b1}};
        seen = 1'b0;
        if (BLANK_LZ != 0) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                seen    = seen | (result_n[i*DIGIT_W +: DIGIT_W] != 4'd0);
                dv_n[i] = seen | (i == 0);
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_finish = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    do_load = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (cnt_q == CNT_W'(1)) state_n = FINISH;
            end
            FINISH: begin
                do_finish = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            digit_valid <= DV_RST;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_n;
            done    <= 1'b0;
            if (do_load) begin
                bin_q     <= value;
                scratch_q <= '0;
                cnt_q     <= CNT_W'(BIN_W);
                sat_q     <= sat_in;
                busy      <= 1'b1;
            end
            if (do_shift) begin
                scratch_q <= shifted;
                bin_q     <= bin_q << 1;
                cnt_q     <= cnt_q - CNT_W'(1);
            end
            if (do_finish) begin
                bcd         <= result_n;
                overflow    <= sat_q;
                digit_valid <= dv_n;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_serial.sv
module tb_score_bcd_serial;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET;

    logic        start, busy, done, overflow;
    logic [17:0] value;
    logic [19:0] bcd;
    logic [4:0]  dv;

    logic        start8, busy8, done8, ovf8;
    logic [7:0]  value8;
    logic [11:0] bcd8;
    logic [2:0]  dv8;

    logic        start14, busy14, done14, ovf14;
    logic [13:0] value14;
    logic [15:0] bcd14;
    logic [3:0]  dv14;

    score_bcd_serial u_dut (
        .CLK(CLK), .RESET(RESET), .start(start), .value(value),
        .busy(busy), .done(done), .bcd(bcd), .digit_valid(dv), .overflow(overflow)
    );

    score_bcd_serial #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0)) u_dut8 (
        .CLK(CLK), .RESET(RESET), .start(start8), .value(value8),
        .busy(busy8), .done(done8), .bcd(bcd8), .digit_valid(dv8), .overflow(ovf8)
    );

    score_bcd_serial #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) u_dut14 (
        .CLK(CLK), .RESET(RESET), .start(start14), .value(value14),
        .busy(busy14), .done(done14), .bcd(bcd14), .digit_valid(dv14), .overflow(ovf14)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [17:0] value;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_dv;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by division, clamped to 10**d-1.
    function automatic longint lim(input int d);
        longint m;
        m = 1;
        for (int i = 0; i < d; i++) m = m * 10;
        return m - 1;
    endfunction

    function automatic logic [63:0] model_bcd(input longint v, input int d);
        logic [63:0] r;
        longint x;
        r = '0;
        x = (v > lim(d)) ? lim(d) : v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] model_ovf(input longint v, input int d);
        return (v > lim(d)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] model_dv(input longint v, input int d, input bit blank);
        longint x;
        int n;
        if (!blank) return (64'd1 << d) - 64'd1;
        x = (v > lim(d)) ? lim(d) : v;
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic conv_main(input logic [17:0] v, input logic [19:0] e_bcd,
                             input logic [4:0] e_dv, input logic e_ovf, input string tag);
        int lat;
        logic [63:0] e;
        exp_q.push_back({44'd0, e_bcd});
        start = 1'b1;
        value = v;
        @(posedge CLK); #1;
        start = 1'b0;
        value = 18'($urandom);
        check({tag, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd19);
        e = exp_q.pop_front();
        check({tag, " bcd"}, 64'(bcd), e);
        check({tag, " dv"}, 64'(dv), 64'(e_dv));
        check({tag, " ovf"}, 64'(overflow), 64'(e_ovf));
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        @(posedge CLK); #1;
        check({tag, " done_1cyc"}, 64'(done), 64'd0);
        check({tag, " bcd_hold"}, 64'(bcd), e);
    endtask

    task automatic conv8(input logic [7:0] v);
        int lat;
        start8 = 1'b1;
        value8 = v;
        @(posedge CLK); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("w8 latency", 64'(lat), 64'd9);
        check("w8 bcd", 64'(bcd8), model_bcd(longint'(v), 3));
        check("w8 dv", 64'(dv8), model_dv(longint'(v), 3, 1'b0));
        check("w8 ovf", 64'(ovf8), model_ovf(longint'(v), 3));
    endtask

    task automatic conv14(input logic [13:0] v);
        int lat;
        start14 = 1'b1;
        value14 = v;
        @(posedge CLK); #1;
        start14 = 1'b0;
        lat = 0;
        while (!done14 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("w14 latency", 64'(lat), 64'd15);
        check("w14 bcd", 64'(bcd14), model_bcd(longint'(v), 4));
        check("w14 dv", 64'(dv14), model_dv(longint'(v), 4, 1'b1));
        check("w14 ovf", 64'(ovf14), model_ovf(longint'(v), 4));
    endtask

    initial begin
        int lat;
        int dones;
        logic [17:0] rv;

        vecs[0] = '{18'd12345,  20'h12345, 5'b11111, 1'b0};
        vecs[1] = '{18'd907,    20'h00907, 5'b00111, 1'b0};
        vecs[2] = '{18'd0,      20'h00000, 5'b00001, 1'b0};
        vecs[3] = '{18'h3FFFF,  20'h99999, 5'b11111, 1'b1};
        vecs[4] = '{18'd42,     20'h00042, 5'b00011, 1'b0};
        vecs[5] = '{18'd99999,  20'h99999, 5'b11111, 1'b0};
        vecs[6] = '{18'd100000, 20'h99999, 5'b11111, 1'b1};
        vecs[7] = '{18'd10,     20'h00010, 5'b00011, 1'b0};

        RESET = 1'b1;
        start = 1'b0;   value = '0;
        start8 = 1'b0;  value8 = '0;
        start14 = 1'b0; value14 = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst ovf", 64'(overflow), 64'd0);
        check("rst bcd", 64'(bcd), 64'd0);
        check("rst dv", 64'(dv), 64'd1);
        check("rst dv8", 64'(dv8), 64'd7);
        check("rst dv14", 64'(dv14), 64'd1);
        RESET = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            conv_main(vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_dv, vecs[i].exp_ovf,
                      $sformatf("vec%0d", i));
        end

        // Starts while busy are ignored.
        start = 1'b1;
        value = 18'd1234;
        @(posedge CLK); #1;
        value = 18'd999;
        dones = 0;
        for (int c = 1; c <= 45; c++) begin
            start = (c == 3 || c == 10);
            @(posedge CLK); #1;
            if (done) dones++;
        end
        start = 1'b0;
        check("ignore dones", 64'(dones), 64'd1);
        check("ignore bcd", 64'(bcd), 64'h01234);

        // Start during the done cycle is accepted.
        start = 1'b1;
        value = 18'd300;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("chain1 bcd", 64'(bcd), 64'h00300);
        start = 1'b1;
        value = 18'd500;
        @(posedge CLK); #1;
        start = 1'b0;
        check("chain2 busy", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("chain2 latency", 64'(lat), 64'd19);
        check("chain2 bcd", 64'(bcd), 64'h00500);
        check("chain2 dv", 64'(dv), 64'b00111);

        // Reset in the middle of SHIFT after a prior result.
        conv_main(18'd777, 20'h00777, 5'b00111, 1'b0, "pre_rst");
        start = 1'b1;
        value = 18'd123;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst bcd", 64'(bcd), 64'd0);
        check("midrst dv", 64'(dv), 64'd1);
        check("midrst ovf", 64'(overflow), 64'd0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            if (done) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);

        // Randomized values against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            rv = (i % 4 == 0) ? 18'($urandom_range(100000, 262143))
                              : 18'($urandom_range(0, 99999));
            conv_main(rv, 20'(model_bcd(longint'(rv), 5)), 5'(model_dv(longint'(rv), 5, 1'b1)),
                      model_ovf(longint'(rv), 5) != 0, $sformatf("rnd%0d", i));
        end

        // Other parameterisations.
        conv8(8'd255);
        conv8(8'd0);
        conv8(8'd7);
        conv8(8'($urandom_range(0, 255)));
        conv14(14'd16383);
        conv14(14'd9999);
        conv14(14'd10000);
        conv14(14'd0);
        conv14(14'($urandom_range(0, 16383)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
